sha256_msg_sched: RTL and testbench
===================================

# sha256_msg_sched

SHA-256 message-schedule stage directly upstream of the hash round core in the mining datapath. It accepts one 512-bit message block and streams the 64 schedule words W0..W63 to the round core, one word per accepted handshake. W0..W15 are the block words. W16..W63 are generated on the fly from a 16-word sliding window. The block holds no round state; the round core consumes w_data/w_idx and applies the constants K[t] itself.

## Interface
- No parameters. Widths are fixed by SHA-256: 32-bit words, 64 schedule words, 6-bit index.
- clk  input  1  sole clock. All state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to load block_in. Honoured only in IDLE.
- block_in  input  512  message block. Word 0 = bits [511:480], word 15 = bits [31:0], big-endian per FIPS 180-4.
- busy  output  1  high while in RUN.
- w_valid  output  1  w_data/w_idx/w_last are valid.
- w_ready  input  1  the round core accepts the current word.
- w_data  output  32  schedule word W[w_idx].
- w_idx  output  6  index t of the current word (0..63).
- w_last  output  1  high together with w_valid when w_idx == 63.
- done  output  1  one-cycle pulse after W63 is accepted.

## Operation
- State machine with two states, IDLE and RUN.
- IDLE, start=1:
  - Load the window win[0..15] from block_in (win[0] = word 0).
  - Clear idx to 0.
  - Move to RUN.
- RUN:
  - w_valid=1, w_data=win[0], w_idx=idx.
  - When w_valid && w_ready (a transfer):
    - Shift the window down by one (win[i] <= win[i+1]).
    - Load win[15] with σ1(win[14]) + win[9] + σ0(win[1]) + win[0], computed mod 2^32.
    - idx <= idx+1.
  - With win[0]=W[t], the new word is W[t+16].
  - When w_ready=0 (stall): window, idx and outputs hold unchanged.
- σ0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x). σ1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
- Additions use 32-bit wrap-around. Carries out of bit 31 are discarded.
- Words generated past W63 are computed but never presented.
- A transfer with idx==63 ends the block: next state IDLE, done=1 for exactly one cycle, idx returns to 0.
- start while in RUN is ignored. block_in is sampled only on an accepted start.
- rst=1 at any time, including mid-block:
  - State goes to IDLE; busy, w_valid, w_last, done = 0; w_idx = 0; w_data = 0.
  - Window contents are cleared to zero.
  - No partial block resumes after reset.
- Reset dominates start in the same cycle.

## Timing
- Reset values: busy=0, w_valid=0, w_last=0, done=0, w_idx=0, w_data=0.
- Start to first word: start accepted on edge N, so w_valid=1 with W0 and w_idx=0 from cycle N+1.
- Throughput is one word per cycle while w_ready=1. With no stalls, W63 is presented at cycle N+64.
- A block needs at least 64 transfer cycles.
- For a last transfer on edge T:
  - In cycle T+1: w_valid=0, busy=0, done=1.
  - A start in cycle T+1 is accepted (state is IDLE), and the next block's W0 appears at T+2.
  - Minimum block-to-block gap: one idle cycle.
- w_data, w_idx and w_last are registered outputs with no combinational path from w_ready.
- w_ready may be asserted before w_valid and has no effect in IDLE.

## Test plan
- "abc" padded block (word0=0x61626380, words1..14=0, word15=0x00000018), w_ready tied high:
  - W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000F0000.
  - done pulses one cycle after W63; 64 transfers total.
- All-ones block: W16=0x203FFFFC, which checks the mod-2^32 wrap. W0..W15=0xFFFFFFFF.
- Random w_ready stalls (≈50% duty) on the "abc" block:
  - Word sequence is identical to the no-stall run.
  - w_data/w_idx stay constant during every stall.
  - w_last appears only with idx 63.
- start pulsed with a different block_in during RUN (idx=10): it is ignored, and the remaining words match the original block.
- rst asserted at idx=30:
  - Next cycle all outputs are at reset values.
  - A new start then yields W0 of the new block at idx 0.
- Back-to-back blocks, with start in the done cycle: the second block's W0 appears two cycles after the first block's last transfer, and both schedules match the software model.

Source files
------------

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: loads one 512-bit block and streams W0..W63 through a valid/ready port.
// First word one cycle after start; one word per cycle when w_ready is high; w_ready low holds every output.
module sha256_msg_sched (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [511:0] block_in,
  output logic         busy,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_data,
  output logic [5:0]   w_idx,
  output logic         w_last,
  output logic         done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nxt;
  logic [31:0] win [16];
  logic [5:0]  idx;
  logic        done_q;
  logic        load;
  logic        xfer;
  logic [31:0] w_new;

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  assign load  = (state == IDLE) && start;
  assign xfer  = (state == RUN) && w_ready;
  // With win[0] = W[t] this is W[t+16]; values past W63 are produced but never presented.
  assign w_new = ssig1(win[14]) + win[9] + ssig0(win[1]) + win[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (w_ready && (idx == 6'd63)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state == RUN);
    w_valid = (state == RUN);
    w_data  = (state == RUN) ? win[0] : 32'd0;
    w_idx   = idx;
    w_last  = (state == RUN) && (idx == 6'd63);
    done    = done_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) win[i] <= 32'd0;
    end else if (load) begin
      for (int i = 0; i < 16; i++) win[i] <= block_in[511 - 32*i -: 32];
    end else if (xfer) begin
      for (int i = 0; i < 15; i++) win[i] <= win[i+1];
      win[15] <= w_new;
    end
  end

  // idx wraps 63 -> 0 on the last transfer, ready for the next block.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= 6'd0;
      done_q <= 1'b0;
    end else begin
      done_q <= xfer && (idx == 6'd63);
      if (load) begin
        idx <= 6'd0;
      end else if (xfer) begin
        idx <= idx + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed bench for sha256_msg_sched: known schedule constants plus a FIPS-style W[t] recurrence model.
module tb_sha256_msg_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [511:0] block_in;
  logic         busy;
  logic         w_valid;
  logic         w_ready;
  logic [31:0]  w_data;
  logic [5:0]   w_idx;
  logic         w_last;
  logic         done;

  localparam logic [511:0] BLK_ABC  = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_ONES = {512{1'b1}};

  int          npass = 0;
  int          ntot  = 0;
  logic [31:0] model_w [64];
  logic [31:0] got_d [64];
  logic [5:0]  got_i [64];
  int          viol;
  int          lastbad;
  int          first_bad;

  sha256_msg_sched dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .block_in (block_in),
    .busy     (busy),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .w_data   (w_data),
    .w_idx    (w_idx),
    .w_last   (w_last),
    .done     (done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_s0(input logic [31:0] x);
    return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] m_s1(input logic [31:0] x);
    return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
  endfunction

  task automatic build_model(input logic [511:0] b);
    for (int t = 0; t < 16; t++) model_w[t] = b[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      model_w[t] = m_s1(model_w[t-2]) + model_w[t-7] + m_s0(model_w[t-15]) + model_w[t-16];
  endtask

  function automatic int count_bad();
    int n = 0;
    first_bad = -1;
    for (int t = 0; t < 64; t++) begin
      if (got_d[t] !== model_w[t] || got_i[t] !== 6'(t)) begin
        if (first_bad < 0) first_bad = t;
        n++;
      end
    end
    return n;
  endfunction

  // Called and returns at #1 after a rising edge; returns in the cycle after the last recorded transfer.
  task automatic collect(input int base, input int count, input bit stall, output int ncyc, output int nwords);
    bit          prev_stall = 1'b0;
    logic [31:0] pd = '0;
    logic [5:0]  pi = '0;
    nwords = 0;
    ncyc   = 0;
    while (nwords < count && ncyc < 2000) begin
      if (prev_stall && (w_data !== pd || w_idx !== pi)) viol++;
      if (w_last !== (w_valid && (w_idx == 6'd63))) lastbad++;
      w_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (w_valid && w_ready) begin
        got_d[base + nwords] = w_data;
        got_i[base + nwords] = w_idx;
        nwords++;
      end
      prev_stall = w_valid && !w_ready;
      pd = w_data;
      pi = w_idx;
      ncyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic do_start(input logic [511:0] b);
    start    = 1'b1;
    block_in = b;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; w_ready = 1'b0; block_in = '0;
    repeat (3) @(posedge clk);
    #1;
    ntot++;
    if ({busy, w_valid, w_last, done, w_idx, w_data} !== 42'd0)
      $display("FAIL reset_outputs: got %h want 0", {busy, w_valid, w_last, done, w_idx, w_data});
    else npass++;
    rst = 1'b0;
    w_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    ntot++;
    if ({busy, w_valid, done} !== 3'b000)
      $display("FAIL idle_ready_noeffect: busy/valid/done=%b want 000", {busy, w_valid, done});
    else npass++;
  endtask

  task automatic test_abc();
    int ncyc, nw, nb;
    build_model(BLK_ABC);
    do_start(BLK_ABC);
    ntot++;
    if (w_valid !== 1'b1 || w_idx !== 6'd0 || w_data !== 32'h61626380)
      $display("FAIL abc_first_word: valid=%b idx=%0d data=%h want 1 0 61626380", w_valid, w_idx, w_data);
    else npass++;
    viol = 0; lastbad = 0;
    collect(0, 64, 1'b0, ncyc, nw);
    ntot++;
    if (nw !== 64 || ncyc !== 64)
      $display("FAIL abc_throughput: words=%0d cycles=%0d want 64 64", nw, ncyc);
    else npass++;
    ntot++;
    if (got_d[0] !== 32'h61626380 || got_d[15] !== 32'h00000018 ||
        got_d[16] !== 32'h61626380 || got_d[17] !== 32'h000F0000)
      $display("FAIL abc_known_words: W0=%h W15=%h W16=%h W17=%h want 61626380 00000018 61626380 000f0000",
               got_d[0], got_d[15], got_d[16], got_d[17]);
    else npass++;
    nb = count_bad();
    ntot++;
    if (nb !== 0) $display("FAIL abc_schedule: %0d bad words, first t=%0d got %h want %h",
                           nb, first_bad, got_d[first_bad], model_w[first_bad]);
    else npass++;
    ntot++;
    if ({done, w_valid, busy} !== 3'b100)
      $display("FAIL abc_done_cycle: done/valid/busy=%b want 100", {done, w_valid, busy});
    else npass++;
    @(posedge clk); #1;
    ntot++;
    if (done !== 1'b0) $display("FAIL abc_done_pulse_width: done=%b want 0", done);
    else npass++;
    ntot++;
    if (lastbad !== 0) $display("FAIL abc_w_last: %0d cycles with wrong w_last want 0", lastbad);
    else npass++;
  endtask

  task automatic test_ones();
    int ncyc, nw, nb;
    build_model(BLK_ONES);
    do_start(BLK_ONES);
    collect(0, 64, 1'b0, ncyc, nw);
    ntot++;
    if (got_d[0] !== 32'hFFFFFFFF || got_d[16] !== 32'h203FFFFC)
      $display("FAIL ones_wrap: W0=%h W16=%h want ffffffff 203ffffc", got_d[0], got_d[16]);
    else npass++;
    nb = count_bad();
    ntot++;
    if (nb !== 0 || nw !== 64) $display("FAIL ones_schedule: words=%0d bad=%0d first t=%0d want 64 0",
                                        nw, nb, first_bad);
    else npass++;
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    int ncyc, nw, nb;
    build_model(BLK_ABC);
    do_start(BLK_ABC);
    viol = 0; lastbad = 0;
    collect(0, 64, 1'b1, ncyc, nw);
    nb = count_bad();
    ntot++;
    if (nb !== 0 || nw !== 64) $display("FAIL stall_schedule: words=%0d bad=%0d first t=%0d want 64 0",
                                        nw, nb, first_bad);
    else npass++;
    ntot++;
    if (viol !== 0) $display("FAIL stall_hold: %0d stall cycles changed data/idx want 0", viol);
    else npass++;
    ntot++;
    if (lastbad !== 0) $display("FAIL stall_w_last: %0d cycles with wrong w_last want 0", lastbad);
    else npass++;
    ntot++;
    if (done !== 1'b1) $display("FAIL stall_done: done=%b want 1", done);
    else npass++;
    @(posedge clk); #1;
  endtask

  task automatic test_start_ignored();
    int ncyc, nw1, nw2, nw3, nb;
    build_model(BLK_ABC);
    do_start(BLK_ABC);
    collect(0, 10, 1'b0, ncyc, nw1);
    ntot++;
    if (w_idx !== 6'd10) $display("FAIL ign_setup_idx: idx=%0d want 10", w_idx);
    else npass++;
    start = 1'b1;
    block_in = BLK_ONES;
    collect(10, 1, 1'b0, ncyc, nw2);
    start = 1'b0;
    ntot++;
    if (busy !== 1'b1 || w_idx !== 6'd11) $display("FAIL ign_still_running: busy=%b idx=%0d want 1 11", busy, w_idx);
    else npass++;
    collect(11, 53, 1'b0, ncyc, nw3);
    nb = count_bad();
    ntot++;
    if (nb !== 0 || nw1 + nw2 + nw3 !== 64)
      $display("FAIL ign_schedule: words=%0d bad=%0d first t=%0d want 64 0", nw1 + nw2 + nw3, nb, first_bad);
    else npass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int ncyc, nw, nb;
    do_start(BLK_ONES);
    collect(0, 30, 1'b0, ncyc, nw);
    rst = 1'b1;
    start = 1'b1;
    block_in = BLK_ABC;
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b0;
    ntot++;
    if ({busy, w_valid, w_last, done, w_idx, w_data} !== 42'd0)
      $display("FAIL midreset_outputs: got %h want 0", {busy, w_valid, w_last, done, w_idx, w_data});
    else npass++;
    build_model(BLK_ABC);
    do_start(BLK_ABC);
    ntot++;
    if (w_valid !== 1'b1 || w_idx !== 6'd0 || w_data !== 32'h61626380)
      $display("FAIL midreset_restart: valid=%b idx=%0d data=%h want 1 0 61626380", w_valid, w_idx, w_data);
    else npass++;
    collect(0, 64, 1'b0, ncyc, nw);
    nb = count_bad();
    ntot++;
    if (nb !== 0 || nw !== 64) $display("FAIL midreset_schedule: words=%0d bad=%0d first t=%0d want 64 0",
                                        nw, nb, first_bad);
    else npass++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int ncyc, nw, nb;
    build_model(BLK_ABC);
    do_start(BLK_ABC);
    collect(0, 64, 1'b0, ncyc, nw);
    nb = count_bad();
    ntot++;
    if (nb !== 0 || nw !== 64) $display("FAIL b2b_first_schedule: words=%0d bad=%0d want 64 0", nw, nb);
    else npass++;
    ntot++;
    if (done !== 1'b1) $display("FAIL b2b_done: done=%b want 1", done);
    else npass++;
    build_model(BLK_ONES);
    do_start(BLK_ONES);
    ntot++;
    if (w_valid !== 1'b1 || w_idx !== 6'd0 || w_data !== 32'hFFFFFFFF)
      $display("FAIL b2b_second_w0: valid=%b idx=%0d data=%h want 1 0 ffffffff", w_valid, w_idx, w_data);
    else npass++;
    collect(0, 64, 1'b0, ncyc, nw);
    nb = count_bad();
    ntot++;
    if (nb !== 0 || nw !== 64) $display("FAIL b2b_second_schedule: words=%0d bad=%0d first t=%0d want 64 0",
                                        nw, nb, first_bad);
    else npass++;
  endtask

  initial begin
    test_reset();
    test_abc();
    test_ones();
    test_stall();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
